bus_rr_arbit: RTL and testbench

BUS_RR_ARBIT -- requirements
Module: bus_rr_arbit

---
 rtl/bus_rr_arbit.sv | 125 ++++++++++++
 tb/tb_bus_rr_arbit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbit.sv
`default_nettype none
// ============================================================================
// Module      : bus_rr_arbit
// Description : Four-master round-robin bus arbiter. A grant is held while
//               its owner keeps requesting; every handover passes through one
//               idle (turnaround) cycle. Optional hold-timeout revocation is
//               enabled by defining the macro BUS_ARBIT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_arbit #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] m_req,
    output logic [3:0] m_grant,
    output logic       m_busy,
    output logic [1:0] m_owner,
    output logic       m_timeout
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_GRANT = 1'b1;

    // Catch an out-of-range hold limit at elaboration time
    generate
        if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range_err
            $error("bus_rr_arbit: TIMEOUT must be within 2..255");
        end
    endgenerate

    logic [0:0] r_state;
    logic [1:0] r_last;
    logic [1:0] w_winner;
    logic [1:0] w_scan;
    logic       w_any_req;
    logic       w_owner_req;
    logic       w_revoke;

    assign w_any_req   = |m_req;
    assign w_owner_req = m_req[m_owner];

    // Round-robin pick: scan last+1 .. last+4 (mod 4); the descending loop
    // lets the closest requester after the pointer overwrite the others.
    always_comb begin
        w_winner = r_last;
        w_scan   = r_last;
        for (int i = 4; i >= 1; i--) begin
            w_scan = r_last + 2'(i);
            if (m_req[w_scan]) begin
                w_winner = w_scan;
            end
        end
    end

`ifdef BUS_ARBIT_TIMEOUT_EN
    localparam logic [7:0] c_HOLD_MAX = 8'(TIMEOUT - 1);

    logic [7:0] r_hold_cnt;
    logic       w_contended;

    // Any request other than the current owner's counts as contention
    assign w_contended = |(m_req & ~m_grant);
    assign w_revoke    = (r_hold_cnt == c_HOLD_MAX) && w_contended;

    // Hold counter (saturating) and the one-cycle revocation pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= 8'd0;
            m_timeout  <= 1'b0;
        end else begin
            m_timeout <= (r_state == c_GRANT) && w_owner_req && w_revoke;
            if (r_state == c_IDLE) begin
                r_hold_cnt <= 8'd0;
            end else if (r_hold_cnt != c_HOLD_MAX) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end
`else
    // Grants are held indefinitely; no revocation logic exists
    assign w_revoke  = 1'b0;
    assign m_timeout = 1'b0;
`endif

    // Arbitration FSM and registered grant outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_last  <= 2'd3;
            m_grant <= 4'b0000;
            m_busy  <= 1'b0;
            m_owner <= 2'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_req) begin
                        r_state <= c_GRANT;
                        r_last  <= w_winner;
                        m_grant <= 4'b0001 << w_winner;
                        m_busy  <= 1'b1;
                        m_owner <= w_winner;
                    end
                end
                c_GRANT: begin
                    // Release (or forced revoke) always passes through IDLE
                    if (!w_owner_req || w_revoke) begin
                        r_state <= c_IDLE;
                        m_grant <= 4'b0000;
                        m_busy  <= 1'b0;
                        m_owner <= 2'd0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    m_grant <= 4'b0000;
                    m_busy  <= 1'b0;
                    m_owner <= 2'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_arbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_rr_arbit
// Description : Directed self-checking bench for bus_rr_arbit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rr_arbit;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] m_req;
    logic [3:0] m_grant;
    logic       m_busy;
    logic [1:0] m_owner;
    logic       m_timeout;

    int checks = 0;
    int errors = 0;
    bit inv_en = 1'b0;

    always #5 clk = ~clk;

    bus_rr_arbit #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .m_req     (m_req),
        .m_grant   (m_grant),
        .m_busy    (m_busy),
        .m_owner   (m_owner),
        .m_timeout (m_timeout)
    );

    // Structural invariants sampled on every falling edge
    always @(negedge clk) begin
        if (inv_en) begin
            checks++;
            if (!$onehot0(m_grant)) begin
                errors++;
                $display("FAIL inv_onehot: m_grant=%b must be one-hot or zero", m_grant);
            end
            checks++;
            if (m_busy !== (|m_grant)) begin
                errors++;
                $display("FAIL inv_busy: m_busy=%b expected %b", m_busy, |m_grant);
            end
            checks++;
            if (m_busy ? (m_grant !== (4'b0001 << m_owner)) : (m_owner !== 2'd0)) begin
                errors++;
                $display("FAIL inv_owner: m_owner=%0d m_grant=%b", m_owner, m_grant);
            end
        end
    end

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_req   = 4'b0000;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m_req   = 4'b0000;
        step();
        step();
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL rst_grant: m_grant=%b expected 0000", m_grant); end
        checks++;
        if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: m_busy=%b expected 0", m_busy); end
        checks++;
        if (m_owner !== 2'd0) begin errors++; $display("FAIL rst_owner: m_owner=%0d expected 0", m_owner); end
        checks++;
        if (m_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: m_timeout=%b expected 0", m_timeout); end
        inv_en = 1'b1;

        // First arbitration at the first edge with reset released
        reset_n = 1'b1;
        m_req   = 4'b0001;
        step();
        checks++;
        if (m_grant !== 4'b0001) begin errors++; $display("FAIL rst_first_grant: m_grant=%b expected 0001", m_grant); end

        // Reset mid-grant must drop the grant without a clock edge
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL rst_async_drop: m_grant=%b expected 0000", m_grant); end
        checks++;
        if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_async_busy: m_busy=%b expected 0", m_busy); end
        step();
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL rst_held: m_grant=%b expected 0000", m_grant); end
        reset_n = 1'b1;
        step();
        checks++;
        if (m_grant !== 4'b0001) begin errors++; $display("FAIL rst_regrant: m_grant=%b expected 0001", m_grant); end
        m_req = 4'b0000;
        step();
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL rst_release: m_grant=%b expected 0000", m_grant); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            m_req = 4'b1111;
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if (m_grant !== exp_g) begin
                    errors++;
                    $display("FAIL rr_grant k=%0d c=%0d: m_grant=%b expected %b", k, c, m_grant, exp_g);
                end
            end
            checks++;
            if (m_owner !== 2'(k % 4)) begin
                errors++;
                $display("FAIL rr_owner k=%0d: m_owner=%0d expected %0d", k, m_owner, k % 4);
            end
            m_req = 4'b1111 & ~exp_g;
            step();
            checks++;
            if (m_grant !== 4'b0000) begin
                errors++;
                $display("FAIL rr_idle k=%0d: m_grant=%b expected 0000", k, m_grant);
            end
        end
        m_req = 4'b0000;
        step();
    endtask

    task automatic test_hold_turnaround();
        // Pointer is at 0 here, so a lone request from master 2 wins
        m_req = 4'b0100;
        step();
        checks++;
        if (m_grant !== 4'b0100) begin errors++; $display("FAIL hold_first: m_grant=%b expected 0100", m_grant); end
        m_req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (m_grant !== 4'b0100) begin
                errors++;
                $display("FAIL hold_keep c=%0d: m_grant=%b expected 0100", c, m_grant);
            end
        end
        m_req = 4'b0010;
        step();
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL hold_turnaround: m_grant=%b expected 0000", m_grant); end
        step();
        checks++;
        if (m_grant !== 4'b0010) begin errors++; $display("FAIL hold_next: m_grant=%b expected 0010", m_grant); end
        m_req = 4'b0000;
        step();
    endtask

    task automatic test_pointer_skip();
        // Pointer is at 1: master 3 wins a lone request
        m_req = 4'b1000;
        step();
        checks++;
        if (m_grant !== 4'b1000) begin errors++; $display("FAIL ptr_m3: m_grant=%b expected 1000", m_grant); end
        m_req = 4'b0000;
        step();
        m_req = 4'b0101;
        step();
        checks++;
        if (m_grant !== 4'b0001) begin errors++; $display("FAIL ptr_wrap: m_grant=%b expected 0001", m_grant); end
        m_req = 4'b0000;
        step();
        step();
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL ptr_no_latch: m_grant=%b expected 0000", m_grant); end

        // Pointer is at 0: master 3 wins, others queue up during the grant
        m_req = 4'b1000;
        step();
        checks++;
        if (m_grant !== 4'b1000) begin errors++; $display("FAIL skip_m3: m_grant=%b expected 1000", m_grant); end
        m_req = 4'b1101;
        step();
        checks++;
        if (m_grant !== 4'b1000) begin errors++; $display("FAIL skip_hold: m_grant=%b expected 1000", m_grant); end
        m_req = 4'b0100;
        step();
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL skip_idle: m_grant=%b expected 0000", m_grant); end
        step();
        checks++;
        if (m_grant !== 4'b0100) begin errors++; $display("FAIL skip_m2: m_grant=%b expected 0100", m_grant); end
        m_req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        m_req = 4'b0011;
`ifdef BUS_ARBIT_TIMEOUT_EN
        for (int c = 0; c < TIMEOUT; c++) begin
            step();
            checks++;
            if ((m_grant !== 4'b0001) || (m_timeout !== 1'b0)) begin
                errors++;
                $display("FAIL to_hold c=%0d: m_grant=%b m_timeout=%b expected 0001/0", c, m_grant, m_timeout);
            end
        end
        step();
        checks++;
        if ((m_grant !== 4'b0000) || (m_timeout !== 1'b1)) begin
            errors++;
            $display("FAIL to_pulse: m_grant=%b m_timeout=%b expected 0000/1", m_grant, m_timeout);
        end
        step();
        checks++;
        if ((m_grant !== 4'b0010) || (m_timeout !== 1'b0)) begin
            errors++;
            $display("FAIL to_next: m_grant=%b m_timeout=%b expected 0010/0", m_grant, m_timeout);
        end
        // Late contender after a long uncontended hold: revoked at the next edge
        m_req = 4'b0000;
        step();
        m_req = 4'b0001;
        for (int c = 0; c < 20; c++) step();
        checks++;
        if (m_grant !== 4'b0001) begin errors++; $display("FAIL to_sat_hold: m_grant=%b expected 0001", m_grant); end
        m_req = 4'b0011;
        step();
        checks++;
        if ((m_grant !== 4'b0000) || (m_timeout !== 1'b1)) begin
            errors++;
            $display("FAIL to_late: m_grant=%b m_timeout=%b expected 0000/1", m_grant, m_timeout);
        end
        step();
        checks++;
        if (m_grant !== 4'b0010) begin errors++; $display("FAIL to_late_next: m_grant=%b expected 0010", m_grant); end
`else
        for (int c = 0; c < 3 * TIMEOUT; c++) begin
            step();
            checks++;
            if ((m_grant !== 4'b0001) || (m_timeout !== 1'b0)) begin
                errors++;
                $display("FAIL to_indef c=%0d: m_grant=%b m_timeout=%b expected 0001/0", c, m_grant, m_timeout);
            end
        end
`endif
        m_req = 4'b0000;
        step();
        checks++;
        if (m_grant !== 4'b0000) begin errors++; $display("FAIL to_release: m_grant=%b expected 0000", m_grant); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_hold_turnaround();
        test_pointer_skip();
        test_timeout();
        @(negedge clk);
        inv_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
